// File: rtl/multicycle_ctl.sv
// multicycle_ctl: Moore sequencer for the fibcore multi-cycle datapath.
// Steps fetch/decode/execute/memory/writeback, driving mux selects, write
// enables and ALU control, and stalls on a req/ready memory handshake.
module multicycle_ctl (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctl,
    output logic [1:0] imm_src,
    output logic [1:0] result_src,
    output logic       reg_write,
    output logic       retire,
    output logic       halted,
    output logic [3:0] dbg_state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXEC_R   = 4'd6,
        EXEC_I   = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t state_q, state_d;

    // State register; reset always lands in FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs; everything is forced to 0 while rst is high
    // so a reset mid-request drops mem_req immediately.
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_ctl    = 3'b000;
        imm_src    = 2'b00;
        result_src = 2'b00;
        reg_write  = 1'b0;
        retire     = 1'b0;
        halted     = 1'b0;
        dbg_state  = 4'd0;

        if (!rst) begin
            dbg_state = state_q;
            case (state_q)
                FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                    if (mem_ready) state_d = DECODE;
                end
                DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    imm_src   = (op == OP_JAL) ? 2'b11 : 2'b10;
                    case (op)
                        OP_LW, OP_SW: state_d = (funct3 == 3'b010) ? MEMADR : TRAP;
                        OP_R:         state_d = (funct3 == 3'b000) ? EXEC_R : TRAP;
                        OP_ADDI:      state_d = (funct3 == 3'b000) ? EXEC_I : TRAP;
                        OP_BR:        state_d = (funct3 == 3'b000 || funct3 == 3'b001) ? BRANCH : TRAP;
                        OP_JAL:       state_d = JAL;
                        default:      state_d = TRAP;
                    endcase
                end
                MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    imm_src   = (op == OP_SW) ? 2'b01 : 2'b00;
                    state_d   = (op == OP_SW) ? MEMWRITE : MEMREAD;
                end
                MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready) state_d = MEMWB;
                end
                MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                    retire     = 1'b1;
                    state_d    = FETCH;
                end
                MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                    retire    = mem_ready;
                    if (mem_ready) state_d = FETCH;
                end
                EXEC_R: begin
                    alu_src_a = 2'b10;
                    alu_ctl   = funct7 ? 3'b001 : 3'b000;
                    state_d   = ALUWB;
                end
                EXEC_I: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    state_d   = ALUWB;
                end
                ALUWB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                    state_d   = FETCH;
                end
                BRANCH: begin
                    alu_src_a = 2'b10;
                    alu_ctl   = 3'b001;
                    retire    = 1'b1;
                    pc_write  = (funct3 == 3'b000) ? zero : ~zero;
                    state_d   = FETCH;
                end
                JAL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_write  = 1'b1;
                    state_d   = ALUWB;
                end
                TRAP: begin
                    halted  = 1'b1;
                    state_d = TRAP;
                end
                default: begin
                    state_d = TRAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctl.sv
// tb_multicycle_ctl: directed checks of the multicycle_ctl sequencer.
// Each step drives inputs after the falling edge and compares the whole
// packed output bundle against a hand-written constant for that state.
module tb_multicycle_ctl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write;
    logic [1:0] alu_src_a, alu_src_b, imm_src, result_src;
    logic [2:0] alu_ctl;
    logic       reg_write, retire, halted;
    logic [3:0] dbg_state;

    int tests = 0;
    int failed = 0;

    multicycle_ctl dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_ctl(alu_ctl), .imm_src(imm_src), .result_src(result_src),
        .reg_write(reg_write), .retire(retire), .halted(halted),
        .dbg_state(dbg_state)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Bundle order: req,wr,adr,ir,pc,a[2],b[2],alu[3],imm[2],res[2],rw,retire,halted,dbg[4]
    logic [22:0] obs;
    assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, alu_src_a,
                  alu_src_b, alu_ctl, imm_src, result_src, reg_write, retire,
                  halted, dbg_state};

    localparam logic [22:0] E_ZERO       = 23'd0;
    localparam logic [22:0] E_FETCH_W    = {5'b10000, 2'b00, 2'b10, 3'b000, 2'b00, 2'b10, 3'b000, 4'd0};
    localparam logic [22:0] E_FETCH_R    = {5'b10011, 2'b00, 2'b10, 3'b000, 2'b00, 2'b10, 3'b000, 4'd0};
    localparam logic [22:0] E_DECODE_B   = {5'b00000, 2'b01, 2'b01, 3'b000, 2'b10, 2'b00, 3'b000, 4'd1};
    localparam logic [22:0] E_DECODE_J   = {5'b00000, 2'b01, 2'b01, 3'b000, 2'b11, 2'b00, 3'b000, 4'd1};
    localparam logic [22:0] E_MEMADR_I   = {5'b00000, 2'b10, 2'b01, 3'b000, 2'b00, 2'b00, 3'b000, 4'd2};
    localparam logic [22:0] E_MEMADR_S   = {5'b00000, 2'b10, 2'b01, 3'b000, 2'b01, 2'b00, 3'b000, 4'd2};
    localparam logic [22:0] E_MEMREAD    = {5'b10100, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, 4'd3};
    localparam logic [22:0] E_MEMWB      = {5'b00000, 2'b00, 2'b00, 3'b000, 2'b00, 2'b01, 3'b110, 4'd4};
    localparam logic [22:0] E_MEMWRITE_W = {5'b11100, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, 4'd5};
    localparam logic [22:0] E_MEMWRITE_R = {5'b11100, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 3'b010, 4'd5};
    localparam logic [22:0] E_EXEC_ADD   = {5'b00000, 2'b10, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, 4'd6};
    localparam logic [22:0] E_EXEC_SUB   = {5'b00000, 2'b10, 2'b00, 3'b001, 2'b00, 2'b00, 3'b000, 4'd6};
    localparam logic [22:0] E_EXEC_I     = {5'b00000, 2'b10, 2'b01, 3'b000, 2'b00, 2'b00, 3'b000, 4'd7};
    localparam logic [22:0] E_ALUWB      = {5'b00000, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 3'b110, 4'd8};
    localparam logic [22:0] E_BRANCH_T   = {5'b00001, 2'b10, 2'b00, 3'b001, 2'b00, 2'b00, 3'b010, 4'd9};
    localparam logic [22:0] E_BRANCH_N   = {5'b00000, 2'b10, 2'b00, 3'b001, 2'b00, 2'b00, 3'b010, 4'd9};
    localparam logic [22:0] E_JAL        = {5'b00001, 2'b01, 2'b10, 3'b000, 2'b00, 2'b00, 3'b000, 4'd10};
    localparam logic [22:0] E_TRAP       = {5'b00000, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 3'b001, 4'd15};

    // Advance one cycle: drive inputs just after the falling edge, let them settle.
    task automatic applyStimulus(input logic r, input logic z, input logic rdy);
        @(negedge clk);
        rst       = r;
        zero      = z;
        mem_ready = rdy;
        #1;
    endtask

    task automatic setInstr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op     = o;
        funct3 = f3;
        funct7 = f7;
    endtask

    task automatic checkOutput(input string tag, input logic [22:0] expected);
        tests++;
        assert (obs === expected)
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %06h expected %06h", tag, obs, expected);
        end
    endtask

    // Linear directed sequence covering each instruction class and the reset/trap corners.
    initial begin
        // Reset: outputs all zero, stale mem_ready ignored
        applyStimulus(1'b1, 1'b0, 1'b1); checkOutput("reset0", E_ZERO);
        applyStimulus(1'b1, 1'b0, 1'b1); checkOutput("reset1", E_ZERO);

        // addi x1,x0,5 zero-wait: states 0,1,7,8 then 0
        setInstr(7'b0010011, 3'b000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("addi_fetch", E_FETCH_R);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("addi_decode", E_DECODE_B);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("addi_exec", E_EXEC_I);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("addi_wb", E_ALUWB);

        // lw with 2 fetch waits and 3 read waits: 10 cycles
        setInstr(7'b0000011, 3'b010, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0); checkOutput("lw_fwait0", E_FETCH_W);
        applyStimulus(1'b0, 1'b0, 1'b0); checkOutput("lw_fwait1", E_FETCH_W);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("lw_fetch", E_FETCH_R);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("lw_decode", E_DECODE_B);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("lw_memadr", E_MEMADR_I);
        applyStimulus(1'b0, 1'b0, 1'b0); checkOutput("lw_rwait0", E_MEMREAD);
        applyStimulus(1'b0, 1'b0, 1'b0); checkOutput("lw_rwait1", E_MEMREAD);
        applyStimulus(1'b0, 1'b0, 1'b0); checkOutput("lw_rwait2", E_MEMREAD);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("lw_read", E_MEMREAD);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("lw_memwb", E_MEMWB);

        // bne taken (zero=0) and not taken (zero=1)
        setInstr(7'b1100011, 3'b001, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("bne_fetch", E_FETCH_R);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("bne_decode", E_DECODE_B);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("bne_taken", E_BRANCH_T);
        applyStimulus(1'b0, 1'b1, 1'b1); checkOutput("bne2_fetch", E_FETCH_R);
        applyStimulus(1'b0, 1'b1, 1'b1); checkOutput("bne2_decode", E_DECODE_B);
        applyStimulus(1'b0, 1'b1, 1'b1); checkOutput("bne_nottaken", E_BRANCH_N);

        // beq: inverse sense
        setInstr(7'b1100011, 3'b000, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1); checkOutput("beq_fetch", E_FETCH_R);
        applyStimulus(1'b0, 1'b1, 1'b1); checkOutput("beq_decode", E_DECODE_B);
        applyStimulus(1'b0, 1'b1, 1'b1); checkOutput("beq_taken", E_BRANCH_T);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("beq2_fetch", E_FETCH_R);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("beq2_decode", E_DECODE_B);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("beq_nottaken", E_BRANCH_N);

        // sub and add
        setInstr(7'b0110011, 3'b000, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("sub_fetch", E_FETCH_R);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("sub_decode", E_DECODE_B);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("sub_exec", E_EXEC_SUB);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("sub_wb", E_ALUWB);
        setInstr(7'b0110011, 3'b000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("add_fetch", E_FETCH_R);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("add_decode", E_DECODE_B);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("add_exec", E_EXEC_ADD);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("add_wb", E_ALUWB);

        // jal: 4 cycles, J immediate in DECODE
        setInstr(7'b1101111, 3'b000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("jal_fetch", E_FETCH_R);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("jal_decode", E_DECODE_J);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("jal_jal", E_JAL);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("jal_wb", E_ALUWB);

        // sw with one write wait
        setInstr(7'b0100011, 3'b010, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("sw_fetch", E_FETCH_R);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("sw_decode", E_DECODE_B);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("sw_memadr", E_MEMADR_S);
        applyStimulus(1'b0, 1'b0, 1'b0); checkOutput("sw_wwait", E_MEMWRITE_W);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("sw_write", E_MEMWRITE_R);

        // Illegal opcode traps and stays trapped despite mem_ready toggling
        setInstr(7'b0110111, 3'b000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("ill_fetch", E_FETCH_R);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("ill_decode", E_DECODE_B);
        for (int i = 0; i < 22; i++) begin
            applyStimulus(1'b0, i[0], i[0]);
            checkOutput($sformatf("ill_trap%0d", i), E_TRAP);
        end
        applyStimulus(1'b1, 1'b0, 1'b1); checkOutput("trap_rst", E_ZERO);
        applyStimulus(1'b0, 1'b0, 1'b0); checkOutput("trap_exit", E_FETCH_W);

        // lw with an illegal funct3 also traps
        setInstr(7'b0000011, 3'b000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("badf3_fetch", E_FETCH_R);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("badf3_decode", E_DECODE_B);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("badf3_trap", E_TRAP);
        applyStimulus(1'b1, 1'b0, 1'b0); checkOutput("badf3_rst", E_ZERO);

        // Reset during a stalled MEMWRITE: outputs drop that cycle, then FETCH without retire
        setInstr(7'b0100011, 3'b010, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("swr_fetch", E_FETCH_R);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("swr_decode", E_DECODE_B);
        applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("swr_memadr", E_MEMADR_S);
        applyStimulus(1'b0, 1'b0, 1'b0); checkOutput("swr_wwait", E_MEMWRITE_W);
        applyStimulus(1'b1, 1'b0, 1'b0); checkOutput("swr_rst", E_ZERO);
        applyStimulus(1'b0, 1'b0, 1'b0); checkOutput("swr_refetch", E_FETCH_W);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/multicycle_ctl.md
# multicycle_ctl

Multi-cycle sequencer for the fibcore datapath. It sits beside the register file, ALU and unified instruction/data memory port, decodes the latched instruction, and steps a Moore FSM through fetch/decode/execute/memory/writeback. Each cycle it drives the mux selects, write enables and ALU control. Memory accesses use a req/ready handshake so variable-latency memory can stall the core.

## Interface
Parameters:
- none (state encoding is internal; `dbg_state` encoding is fixed below)

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `op` in 7: opcode from instruction register.
- `funct3` in 3: from instruction register.
- `funct7` in 1: instruction bit 30.
- `zero` in 1: ALU result == 0, same cycle.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory request active.
- `mem_write` out 1: request is a store (valid only with `mem_req`).
- `adr_src` out 1: memory address; 0 = PC, 1 = ALUOut.
- `ir_write` out 1: latch instruction and oldPC.
- `pc_write` out 1: load PC from result bus.
- `alu_src_a` out 2: 00 PC, 01 oldPC, 10 rs1 register.
- `alu_src_b` out 2: 00 rs2 register, 01 immediate, 10 constant 4.
- `alu_ctl` out 3: 000 add, 001 sub.
- `imm_src` out 2: 00 I, 01 S, 10 B, 11 J.
- `result_src` out 2: 00 ALUOut, 01 mem data register, 10 ALU result.
- `reg_write` out 1: register file write of result bus to rd.
- `retire` out 1: one-cycle pulse on an instruction's final cycle.
- `halted` out 1: sticky illegal-instruction trap.
- `dbg_state` out 4: current state code.

## Operation
- Supported instructions:
  - lw 0000011 (f3 010)
  - sw 0100011 (f3 010)
  - add/sub 0110011 (f3 000, `funct7` 0 = add, 1 = sub)
  - addi 0010011 (f3 000)
  - beq/bne 1100011 (f3 000/001)
  - jal 1101111
- Any other op/funct3 combination is decoded in DECODE and moves to TRAP.
- States (dbg_state code):
  - FETCH 0
  - DECODE 1
  - MEMADR 2
  - MEMREAD 3
  - MEMWB 4
  - MEMWRITE 5
  - EXEC_R 6
  - EXEC_I 7
  - ALUWB 8
  - BRANCH 9
  - JAL 10
  - TRAP 15
- Outputs are pure functions of state, plus `mem_ready` and `zero` where noted. Unlisted enables are 0; unlisted selects are 00 / add.
- FETCH:
  - `mem_req`=1, `adr_src`=0, a=PC, b=4, `result_src`=10.
  - `ir_write`=`pc_write`=`mem_ready`.
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE:
  - a=oldPC, b=imm, add. Result is the branch/jal target, latched in ALUOut.
  - `imm_src`=J for jal, else B.
  - Next state by op: lw/sw→MEMADR, R→EXEC_R, addi→EXEC_I, branch→BRANCH, jal→JAL, illegal→TRAP.
- MEMADR:
  - a=rs1, b=imm, add.
  - `imm_src`=S for sw, I for lw.
  - Next state: MEMWRITE for sw, MEMREAD for lw.
- MEMREAD: `mem_req`=1, `adr_src`=1. Holds until `mem_ready`, then MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1, `retire`=1, then FETCH.
- MEMWRITE: `mem_req`=`mem_write`=1, `adr_src`=1. Holds until `mem_ready`; in that cycle `retire`=1, then FETCH.
- EXEC_R: a=rs1, b=rs2, `alu_ctl`=`funct7`?001:000, then ALUWB.
- EXEC_I: a=rs1, b=imm, I-type, add, then ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1, `retire`=1, then FETCH.
- BRANCH:
  - a=rs1, b=rs2, sub, `result_src`=00, `retire`=1.
  - `pc_write` = (f3==000) ? `zero` : ~`zero`.
  - Next state FETCH.
- JAL:
  - a=oldPC, b=4, `result_src`=00, `pc_write`=1.
  - ALUOut now holds oldPC+4; next state ALUWB (writes the link to rd).
- TRAP: every enable is 0, `mem_req`=0, `halted`=1. Only `rst` leaves TRAP.

## Timing
- Reset:
  - `rst`=1 at an edge sets state to FETCH.
  - While `rst`=1, every output is 0 regardless of state, including `dbg_state`=0 and `halted`=0.
  - Reset mid-request drops `mem_req` in the same cycle; a stale `mem_ready` is ignored.
- Cycle counts with zero-wait memory (`mem_ready`=1 on the first request cycle):
  - lw 5
  - sw 4
  - R/I 4
  - branch 3
  - jal 4
- Each wait cycle (`mem_ready`=0 while `mem_req`=1) adds one cycle.
- Handshake: `mem_req`, `mem_write` and `adr_src` stay stable until the `mem_ready` cycle inclusive. `mem_ready` with `mem_req`=0 is ignored.
- `ir_write`/`pc_write` in FETCH and the completion of MEMREAD/MEMWRITE occur only in the `mem_ready` cycle. This means at most one IR/PC update per fetch.
- `retire` is exactly one pulse per completed instruction; it is never asserted in FETCH, DECODE or TRAP.

## Test plan
- Reset, then a zero-wait addi x1,x0,5: `dbg_state` goes 0,1,7,8,0. `reg_write`=1 only in state 8. `retire` pulses once, on cycle 4.
- lw with `mem_ready` low for 2 cycles in FETCH and 3 in MEMREAD: 10 cycles in total. `ir_write` is high in exactly one cycle. `mem_req`/`adr_src` stay stable during the waits.
- bne with `zero`=0 → `pc_write`=1 in BRANCH. Repeat with `zero`=1 → `pc_write`=0. The beq variant gives the inverse; each takes 3 cycles.
- sub (`funct7`=1): `alu_ctl`=001 in EXEC_R. jal: `pc_write` high in JAL, `reg_write` high in ALUWB, 4 cycles.
- Illegal op 0110111: DECODE → TRAP. `halted`=1, all enables 0 for 20+ cycles despite `mem_ready` toggling. `rst` returns to FETCH.
- `rst` asserted in MEMWRITE while `mem_ready`=0: all outputs are 0 that cycle. The next cycle is in FETCH with `mem_req`=1 and no `retire`.
